// File: rtl/lcd_arbmod_if.sv
// ---------------------------------------------------------------------------
// lcd_arbmod_if
// Bundles every non-clock signal of the frame-buffer arbiter: display read
// port, pixel writer port, FIFO status and the single-port RAM port.
//
// Modports
//   slave  : the arbiter itself (takes i* signals, drives o* signals)
//   master : the surrounding logic / testbench (drives i*, observes o*)
//
// Handshake semantics (writer side):
//   A write is transferred in exactly the cycle where iWrReq && oWrReady are
//   both high at the rising clock edge. oWrReady depends only on registered
//   state, never on iWrReq, so the writer may hold iWrReq/iWrAddr/iWrData
//   stable until it sees the transfer. The display read side has no
//   back-pressure: every cycle with iRdReq=1 is served and answered three
//   cycles later with oRdValid.
// ---------------------------------------------------------------------------
interface lcd_arbmod_if #(
  parameter int AW         = 14,
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  // display read side
  logic          iRdReq;
  logic [AW-1:0] iRdAddr;
  logic [DW-1:0] oRdData;
  logic          oRdValid;

  // pixel writer side
  logic          iWrReq;
  logic [AW-1:0] iWrAddr;
  logic [DW-1:0] iWrData;
  logic          oWrReady;
  logic [LW-1:0] oFifoLevel;
  logic          oWrStarve;

  // single-port RAM side
  logic [AW-1:0] oRamAddr;
  logic [DW-1:0] oRamData;
  logic          oRamWe;
  logic [DW-1:0] iRamData;

  modport slave (
    input  iRdReq, iRdAddr, iWrReq, iWrAddr, iWrData, iRamData,
    output oRdData, oRdValid, oWrReady, oFifoLevel, oWrStarve,
           oRamAddr, oRamData, oRamWe
  );

  modport master (
    output iRdReq, iRdAddr, iWrReq, iWrAddr, iWrData, iRamData,
    input  oRdData, oRdValid, oWrReady, oFifoLevel, oWrStarve,
           oRamAddr, oRamData, oRamWe
  );
endinterface

// File: rtl/lcd_arbmod.sv
// ---------------------------------------------------------------------------
// lcd_arbmod
// Single-port frame-buffer arbiter between the LCD scan-out reader and a
// pixel writer. The display read always owns the RAM in a cycle where it
// requests; writes are parked in a small FIFO and retired to the RAM on
// cycles without a read request (blanking, gaps).
//
// Ports
//   CLOCK : pixel clock, all logic on the rising edge
//   RESET : asynchronous, active-low reset
//   bus   : lcd_arbmod_if.slave
//           iRdReq/iRdAddr       -> oRdData/oRdValid (fixed 3-cycle latency)
//           iWrReq/iWrAddr/iWrData, oWrReady, oFifoLevel, oWrStarve
//           oRamAddr/oRamData/oRamWe (registered), iRamData (1-cycle RAM)
//
// Parameters
//   AW, DW      : RAM address / pixel width
//   FIFO_DEPTH  : write FIFO entries, power of two, >= 2
//   STARVE_MAX  : consecutive full-and-reading cycles before oWrStarve sets
// ---------------------------------------------------------------------------
module lcd_arbmod #(
  parameter int AW         = 14,
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 255
) (
  input  logic         CLOCK,
  input  logic         RESET,
  lcd_arbmod_if.slave  bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
  localparam logic [15:0]   STARVE_LIM = 16'(STARVE_MAX);

  // write FIFO storage (no reset needed: validity is tracked by r_level)
  logic [AW-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  // RAM port registers
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_data;
  logic          r_ram_we;

  // read return pipeline
  logic          r_rd_v1;
  logic          r_rd_v2;
  logic          r_rd_valid;
  logic [DW-1:0] r_rd_data;

  // starvation tracking
  logic [15:0]   r_starve_cnt;
  logic          r_starve;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [15:0]   w_starve_nxt;

  always_comb begin
    w_full  = (r_level == FULL_LEVEL);
    w_empty = (r_level == '0);
    // Fullness is judged on the registered level only: a pop in the same
    // cycle does not open a slot for the writer.
    w_push  = bus.iWrReq && !w_full;
    // Display read has absolute priority; the head only leaves on a free cycle.
    w_pop   = !bus.iRdReq && !w_empty;
    // Saturate so a very long stall cannot wrap the counter back to zero.
    w_starve_nxt = (r_starve_cnt == 16'hFFFF) ? r_starve_cnt
                                              : r_starve_cnt + 16'd1;
  end

  // FIFO storage write
  always_ff @(posedge CLOCK) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= bus.iWrAddr;
      r_fifo_data[r_wptr] <= bus.iWrData;
    end
  end

  // control, RAM port, read pipeline, starvation
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_ram_addr   <= '0;
      r_ram_data   <= '0;
      r_ram_we     <= 1'b0;
      r_rd_v1      <= 1'b0;
      r_rd_v2      <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_starve_cnt <= '0;
      r_starve     <= 1'b0;
    end else begin
      // RAM grant
      if (bus.iRdReq) begin
        r_ram_addr <= bus.iRdAddr;
        r_ram_we   <= 1'b0;
      end else if (w_pop) begin
        r_ram_addr <= r_fifo_addr[r_rptr];
        r_ram_data <= r_fifo_data[r_rptr];
        r_ram_we   <= 1'b1;
        r_rptr     <= r_rptr + 1'b1;
      end else begin
        r_ram_we   <= 1'b0;
      end

      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase

      // Stage 1: address is on the RAM. Stage 2: RAM data is on iRamData.
      r_rd_v1    <= bus.iRdReq;
      r_rd_v2    <= r_rd_v1;
      r_rd_valid <= r_rd_v2;
      if (r_rd_v2) begin
        r_rd_data <= bus.iRamData;
      end

      // Starvation: only full cycles that lose to a read count; any cycle
      // with free space restarts the count. The flag is sticky.
      if (!w_full) begin
        r_starve_cnt <= '0;
      end else if (bus.iRdReq) begin
        r_starve_cnt <= w_starve_nxt;
        if (w_starve_nxt == STARVE_LIM) begin
          r_starve <= 1'b1;
        end
      end
    end
  end

  assign bus.oRdData    = r_rd_data;
  assign bus.oRdValid   = r_rd_valid;
  assign bus.oWrReady   = !w_full;
  assign bus.oFifoLevel = r_level;
  assign bus.oWrStarve  = r_starve;
  assign bus.oRamAddr   = r_ram_addr;
  assign bus.oRamData   = r_ram_data;
  assign bus.oRamWe     = r_ram_we;

endmodule

// File: tb/tb_lcd_arbmod.sv
// ---------------------------------------------------------------------------
// tb_lcd_arbmod
// Drives the arbiter through directed scenarios followed by randomized
// traffic, and compares every cycle against a transaction-level model: a
// queue of pending writes, a reference frame buffer, and a queue of read
// results each tagged with the cycle in which it must appear.
// ---------------------------------------------------------------------------
module tb_lcd_arbmod;

  localparam int AW         = 14;
  localparam int DW         = 16;
  localparam int FD         = 4;
  localparam int STARVE_MAX = 8;
  localparam int LW         = $clog2(FD) + 1;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lcd_arbmod_if #(.AW(AW), .DW(DW), .FIFO_DEPTH(FD)) bus ();

  lcd_arbmod #(
    .AW(AW), .DW(DW), .FIFO_DEPTH(FD), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .CLOCK (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  // ---------------- RAM behavioural model attached to the DUT ----------------
  logic [DW-1:0] mem     [2**AW];
  logic [DW-1:0] ref_mem [2**AW];

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem[i]     = DW'(i) ^ 16'hA5A5;
      ref_mem[i] = DW'(i) ^ 16'hA5A5;
    end
    bus.iRamData = '0;
  end

  always @(posedge clk) begin
    if (bus.oRamWe) mem[bus.oRamAddr] <= bus.oRamData;
    bus.iRamData <= mem[bus.oRamAddr];
  end

  // ---------------- reference model state ----------------
  wr_t           m_fifo[$];
  logic [DW-1:0] exp_q[$];      // read data expected, in order
  int            exp_due_q[$];  // cycle index after which each appears
  logic [AW-1:0] m_ram_addr;
  logic [DW-1:0] m_ram_data;
  logic          m_ram_we;
  logic          m_rd_valid;
  logic [DW-1:0] m_rd_data;
  int            m_starve_cnt;
  logic          m_starve;
  int            cyc;

  int n_checks;
  int n_fail;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, t=%0t)",
               tag, obs, exp, cyc, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    exp_q.delete();
    exp_due_q.delete();
    m_ram_addr   = '0;
    m_ram_data   = '0;
    m_ram_we     = 1'b0;
    m_rd_valid   = 1'b0;
    m_rd_data    = '0;
    m_starve_cnt = 0;
    m_starve     = 1'b0;
  endtask

  // One clock of the arbitration rules, applied to the inputs of that cycle.
  task automatic model_step(input bit rd, input logic [AW-1:0] ra,
                            input bit wr, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd);
    bit  full;
    wr_t w;
    full = (m_fifo.size() == FD);
    if (rd) begin
      m_ram_addr = ra;
      m_ram_we   = 1'b0;
      exp_q.push_back(ref_mem[ra]);
      exp_due_q.push_back(cyc + 2);
    end else if (m_fifo.size() > 0) begin
      w = m_fifo.pop_front();
      m_ram_addr = w.a;
      m_ram_data = w.d;
      m_ram_we   = 1'b1;
      ref_mem[w.a] = w.d;
    end else begin
      m_ram_we = 1'b0;
    end
    if (wr && !full) m_fifo.push_back('{a: wa, d: wd});
    if (!full) m_starve_cnt = 0;
    else if (rd) m_starve_cnt++;
    if (m_starve_cnt == STARVE_MAX) m_starve = 1'b1;
    m_rd_valid = 1'b0;
    if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
      void'(exp_due_q.pop_front());
      m_rd_data  = exp_q.pop_front();
      m_rd_valid = 1'b1;
    end
    cyc++;
  endtask

  task automatic check_outputs();
    check_eq("ram_we",    32'(bus.oRamWe),     32'(m_ram_we));
    check_eq("ram_addr",  32'(bus.oRamAddr),   32'(m_ram_addr));
    if (m_ram_we) check_eq("ram_data", 32'(bus.oRamData), 32'(m_ram_data));
    check_eq("rd_valid",  32'(bus.oRdValid),   32'(m_rd_valid));
    if (m_rd_valid) check_eq("rd_data", 32'(bus.oRdData), 32'(m_rd_data));
    check_eq("fifo_level", 32'(bus.oFifoLevel), 32'(m_fifo.size()));
    check_eq("wr_ready",  32'(bus.oWrReady),   32'(m_fifo.size() < FD));
    check_eq("wr_starve", 32'(bus.oWrStarve),  32'(m_starve));
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_cycle(input bit rd, input logic [AW-1:0] ra,
                           input bit wr, input logic [AW-1:0] wa,
                           input logic [DW-1:0] wd);
    @(negedge clk);
    bus.iRdReq  = rd;
    bus.iRdAddr = ra;
    bus.iWrReq  = wr;
    bus.iWrAddr = wa;
    bus.iWrData = wd;
    @(posedge clk);
    if (rst_n) model_step(rd, ra, wr, wa, wd);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic assert_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    bus.iRdReq  = 1'b0;
    bus.iRdAddr = '0;
    bus.iWrReq  = 1'b0;
    bus.iWrAddr = '0;
    bus.iWrData = '0;
    model_reset();

    // 1. reset and idle
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    release_reset();
    idle(20);

    // 2. read only
    for (int i = 0; i < 10; i++) run_cycle(1'b1, AW'(i), 1'b0, '0, '0);
    idle(5);

    // 3. write only
    run_cycle(1'b0, '0, 1'b1, AW'(16'h0010), 16'h1234);
    run_cycle(1'b0, '0, 1'b1, AW'(16'h0011), 16'h5678);
    idle(4);
    check_eq("wr_only_level", 32'(bus.oFifoLevel), 32'd0);

    // 4. contention: five pushes while the display reads
    for (int i = 0; i < 5; i++)
      run_cycle(1'b1, AW'($urandom_range(0, 63)), 1'b1, AW'(16'h20 + i),
                DW'($urandom));
    check_eq("contend_ready", 32'(bus.oWrReady), 32'd0);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, AW'(i), 1'b0, '0, '0);
    idle(6);

    // 5. starvation: fill, keep reading, then drain
    for (int i = 0; i < FD; i++)
      run_cycle(1'b1, AW'(i), 1'b1, AW'(16'h40 + i), DW'($urandom));
    for (int i = 0; i < STARVE_MAX + 4; i++)
      run_cycle(1'b1, AW'(i), 1'b0, '0, '0);
    idle(8);
    check_eq("starve_sticky", 32'(bus.oWrStarve), 32'd1);

    // 6. reset mid-burst: queued writes and in-flight reads
    for (int i = 0; i < 3; i++)
      run_cycle(1'b1, AW'(i + 5), 1'b1, AW'(16'h50 + i), DW'($urandom));
    run_cycle(1'b1, AW'(9), 1'b0, '0, '0);
    assert_reset();
    check_eq("rst_level", 32'(bus.oFifoLevel), 32'd0);
    idle(2);
    release_reset();
    idle(6);
    run_cycle(1'b0, '0, 1'b1, AW'(16'h60), 16'hBEEF);
    for (int i = 0; i < 4; i++) run_cycle(1'b1, AW'(16'h60), 1'b0, '0, '0);
    idle(4);

    // 7. randomized bursty traffic over a small address window (hazards)
    for (int seg = 0; seg < 15; seg++) begin
      int rd_pct;
      int wr_pct;
      rd_pct = (seg % 3 == 0) ? 92 : (seg % 3 == 1) ? 50 : 10;
      wr_pct = $urandom_range(30, 90);
      for (int i = 0; i < 200; i++)
        run_cycle($urandom_range(0, 99) < rd_pct, AW'($urandom_range(0, 31)),
                  $urandom_range(0, 99) < wr_pct, AW'($urandom_range(0, 31)),
                  DW'($urandom));
      if (seg == 7) begin
        assert_reset();
        idle(1);
        release_reset();
      end
    end
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
